// File: rtl/keypad_pkg.sv
// Shared state encoding and counter-sizing helper for the parametrised keypad encoder.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } kp_state_t;

  // Smallest width (at least 1) whose range covers 0..value-1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((32'sd1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-clk tick at the end of every DIV_RATIO period, plus the
// divided-clock phase of the upcoming count so a registered copy lines up with the count.
module tick_prescaler
  import keypad_pkg::*;
#(
  parameter int DIV_RATIO = 100
) (
  input  logic clk,
  input  logic resetn,
  output logic tick,
  output logic phase_hi
);

  localparam int CW = clog2(DIV_RATIO);
  localparam logic [CW-1:0] LAST = CW'(DIV_RATIO - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV_RATIO / 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    if (cnt_q == LAST) cnt_d = {CW{1'b0}};
    else               cnt_d = cnt_q + CW'(1);
  end

  assign tick     = (cnt_q == LAST);
  assign phase_hi = (cnt_d < HALF);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= {CW{1'b0}};
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/param_keypad_encoder.sv
// Priority-encoding, tick-debounced keypad front end with a 1-clk active-low load strobe.
// Optional auto-repeat while a key is held is enabled by defining AUTO_REPEAT_EN.
module param_keypad_encoder
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS       = 10,
  parameter int CODE_W         = 4,
  parameter int DIV_RATIO      = 100,
  parameter int DEBOUNCE_TICKS = 4
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
`endif
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                enablen,
  output logic [CODE_W-1:0]   code,
  output logic                loadn,
  output logic                key_held,
  output logic                pgt_out
);

  localparam int DCW = clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_TICKS);

  logic [NUM_KEYS-1:0] key_s1_q;
  logic [NUM_KEYS-1:0] key_s2_q;
  logic [CODE_W-1:0]   cand_q;
  logic [CODE_W-1:0]   code_q;
  logic [CODE_W-1:0]   pri_s;
  logic [DCW-1:0]      cnt_q;
  kp_state_t           state_q;
  logic                loadn_q;
  logic                loadn_d;
  logic                key_held_q;
  logic                pgt_out_q;
  logic                any_s;
  logic                tick_s;
  logic                phase_hi_s;
  logic                rep_fire_s;

  tick_prescaler #(.DIV_RATIO(DIV_RATIO)) u_prescaler (
    .clk      (clk),
    .resetn   (resetn),
    .tick     (tick_s),
    .phase_hi (phase_hi_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_s1_q <= {NUM_KEYS{1'b0}};
      key_s2_q <= {NUM_KEYS{1'b0}};
    end else begin
      key_s1_q <= keypad;
      key_s2_q <= key_s1_q;
    end
  end

  // Later (higher) indices overwrite earlier ones, so the highest set line wins.
  always_comb begin
    pri_s = {CODE_W{1'b0}};
    for (int i = 0; i < NUM_KEYS; i++) begin
      pri_s = key_s2_q[i] ? CODE_W'(i) : pri_s;
    end
    any_s = (|key_s2_q) & ~enablen;
  end

`ifdef AUTO_REPEAT_EN
  localparam int RCW = clog2(REPEAT_DELAY + 1);
  localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_DELAY);
  localparam logic [RCW-1:0] REP_BACK = RCW'(REPEAT_DELAY - REPEAT_RATE);
  logic [RCW-1:0] rep_q;
  // After the first repeat the counter steps back by REPEAT_RATE, so later repeats hit REP_LAST again.
  assign rep_fire_s = (state_q == ST_HELD) && tick_s && any_s && ((rep_q + RCW'(1)) == REP_LAST);
`else
  assign rep_fire_s = 1'b0;
`endif

  assign loadn_d = ~((state_q == ST_PRESSED) | rep_fire_s);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cand_q     <= {CODE_W{1'b0}};
      cnt_q      <= {DCW{1'b0}};
      code_q     <= {CODE_W{1'b0}};
      loadn_q    <= 1'b1;
      key_held_q <= 1'b0;
      pgt_out_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q      <= {RCW{1'b0}};
`endif
    end else begin
      loadn_q   <= loadn_d;
      pgt_out_q <= enablen ? phase_hi_s : ~loadn_d;
      case (state_q)
        ST_IDLE: begin
          if (tick_s && any_s) begin
            cand_q <= pri_s;
            cnt_q  <= DCW'(1);
            if (DEBOUNCE_TICKS == 1) state_q <= ST_PRESSED;
            else                     state_q <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (tick_s) begin
            if (!any_s) begin
              state_q <= ST_IDLE;
            end else if (pri_s != cand_q) begin
              cand_q <= pri_s;
              cnt_q  <= DCW'(1);
            end else if ((cnt_q + DCW'(1)) == DB_LAST) begin
              state_q <= ST_PRESSED;
            end else begin
              cnt_q <= cnt_q + DCW'(1);
            end
          end
        end
        ST_PRESSED: begin
          code_q     <= cand_q;
          key_held_q <= 1'b1;
          state_q    <= ST_HELD;
`ifdef AUTO_REPEAT_EN
          rep_q      <= {RCW{1'b0}};
`endif
        end
        ST_HELD: begin
          if (tick_s) begin
            if (!any_s) begin
              cnt_q <= DCW'(1);
`ifdef AUTO_REPEAT_EN
              rep_q <= {RCW{1'b0}};
`endif
              if (DEBOUNCE_TICKS == 1) begin
                key_held_q <= 1'b0;
                state_q    <= ST_IDLE;
              end else begin
                state_q <= ST_RELEASE;
              end
            end else begin
`ifdef AUTO_REPEAT_EN
              rep_q <= rep_fire_s ? REP_BACK : rep_q + RCW'(1);
`endif
            end
          end
        end
        ST_RELEASE: begin
          if (tick_s) begin
            if (any_s) begin
              cnt_q   <= {DCW{1'b0}};
              state_q <= ST_HELD;
`ifdef AUTO_REPEAT_EN
              rep_q   <= {RCW{1'b0}};
`endif
            end else if ((cnt_q + DCW'(1)) == DB_LAST) begin
              key_held_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + DCW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign code     = code_q;
  assign loadn    = loadn_q;
  assign key_held = key_held_q;
  assign pgt_out  = pgt_out_q;

endmodule

// File: tb/tb_param_keypad_encoder.sv
// Randomised and directed bench for param_keypad_encoder, checked every clock against a
// run-length reference model of the debounce rules (define AUTO_REPEAT_EN for the repeat test).
module tb_param_keypad_encoder;

  localparam int NK  = 10;
  localparam int CW  = 4;
  localparam int DIV = 4;
  localparam int DB  = 3;
`ifdef AUTO_REPEAT_EN
  localparam int RD  = 5;
  localparam int RR  = 2;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enablen = 1'b0;
  logic [NK-1:0] keypad = '0;
  logic [CW-1:0] code;
  logic          loadn;
  logic          key_held;
  logic          pgt_out;

  int chk_cnt = 0;
  int err_cnt = 0;
  int pulse_cnt = 0;

  // Reference model state: prescaler phase, 2-deep input delay, run lengths.
  int            pcnt;
  logic [NK-1:0] s1, s2;
  bit            m_held, m_pend;
  int            run_len, run_pri, rel_len, rep;
  logic [CW-1:0] m_cand, exp_code;
  logic          exp_loadn, exp_held, exp_pgt;

  param_keypad_encoder #(
    .NUM_KEYS(NK), .CODE_W(CW), .DIV_RATIO(DIV), .DEBOUNCE_TICKS(DB)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
`endif
  ) dut (
    .clk(clk), .resetn(resetn), .keypad(keypad), .enablen(enablen),
    .code(code), .loadn(loadn), .key_held(key_held), .pgt_out(pgt_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hi_idx(input logic [NK-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NK; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    pcnt = 0; s1 = '0; s2 = '0;
    m_held = 0; m_pend = 0; run_len = 0; run_pri = 0; rel_len = 0; rep = 0;
    m_cand = '0; exp_code = '0; exp_loadn = 1'b1; exp_held = 1'b0; exp_pgt = 1'b0;
  endtask

  // A key is accepted after DB consecutive tick samples of the same top key; released after DB empty samples.
  task automatic model_edge();
    bit tick, any;
    int pri;
    tick = (pcnt == DIV - 1);
    any  = (s2 != '0) && !enablen;
    pri  = hi_idx(s2);
    exp_loadn = 1'b1;
    if (m_pend) begin
      m_pend = 0; exp_loadn = 1'b0; exp_code = m_cand; exp_held = 1'b1;
    end else if (tick) begin
      if (!m_held) begin
        if (!any) run_len = 0;
        else if (run_len > 0 && pri == run_pri) run_len++;
        else begin run_pri = pri; run_len = 1; end
        if (run_len == DB) begin
          m_pend = 1; m_held = 1; m_cand = CW'(run_pri);
          run_len = 0; rel_len = 0; rep = 0;
        end
      end else if (any) begin
        if (rel_len > 0) begin
          rel_len = 0; rep = 0;
        end else begin
          rep++;
`ifdef AUTO_REPEAT_EN
          if (rep >= RD && ((rep - RD) % RR) == 0) exp_loadn = 1'b0;
`endif
        end
      end else begin
        rel_len++; rep = 0;
        if (rel_len == DB) begin m_held = 0; exp_held = 1'b0; rel_len = 0; end
      end
    end
    s2 = s1; s1 = keypad; pcnt = (pcnt + 1) % DIV;
    exp_pgt = enablen ? (pcnt < DIV / 2) : !exp_loadn;
  endtask

  task automatic step();
    @(posedge clk);
    if (!resetn) model_reset();
    else         model_edge();
    #1;
    check_val("loadn", loadn, exp_loadn);
    check_val("code", code, exp_code);
    check_val("key_held", key_held, exp_held);
    check_val("pgt_out", pgt_out, exp_pgt);
    if (!loadn) pulse_cnt++;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    int lat, highs, sel, len;
    bit done;
    model_reset();
    run(3);
    resetn = 1'b1;
    run(5);

    // 1: steady key 7, latency measured from the drive point
    pulse_cnt = 0; keypad = '0; keypad[7] = 1'b1;
    lat = 999; done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      step();
      if (!loadn) begin lat = c; done = 1; end
    end
    check_val("t1_latency_in_range", (lat >= DB * DIV && lat <= DB * DIV + 3), 1);
    check_val("t1_code", code, 7);
    check_val("t1_held", key_held, 1);
    run(3); keypad = '0; run(20);
    check_val("t1_one_pulse", pulse_cnt, 1);
    check_val("t1_released", key_held, 0);

    // 2: simultaneous 2+9, then no rollover from 2 to 9
    keypad[2] = 1'b1; keypad[9] = 1'b1; run(25);
    check_val("t2_priority", code, 9);
    keypad = '0; run(20);
    keypad[2] = 1'b1; run(25);
    check_val("t2_code2", code, 2);
    pulse_cnt = 0; keypad[9] = 1'b1; run(30);
    check_val("t2_no_rollover", code, 2);
    check_val("t2_no_pulse", pulse_cnt, 0);
    keypad = '0; run(20);

    // 3: bounce 1,0,1 across consecutive ticks, then steady
    pulse_cnt = 0;
    keypad[4] = 1'b1; run(4); keypad[4] = 1'b0; run(4); keypad[4] = 1'b1; run(8);
    check_val("t3_no_early_pulse", pulse_cnt, 0);
    run(20);
    check_val("t3_code", code, 4);
    check_val("t3_one_pulse", pulse_cnt, 1);
    keypad = '0; run(20);

    // 4: enablen raised mid-debounce, divided clock on pgt_out
    pulse_cnt = 0; keypad[5] = 1'b1; run(6);
    enablen = 1'b1; run(20);
    check_val("t4_abort_no_pulse", pulse_cnt, 0);
    highs = 0;
    for (int c = 0; c < 8; c++) begin step(); if (pgt_out) highs++; end
    check_val("t4_pgt_duty", highs, 4);
    enablen = 1'b0; run(25);
    check_val("t4_code_after_enable", code, 5);
    keypad = '0; run(20);

    // 5: asynchronous reset while held, then a normal press
    keypad[6] = 1'b1; run(25);
    check_val("t5_held_before_reset", key_held, 1);
    resetn = 1'b0; #1;
    check_val("t5_rst_code", code, 0);
    check_val("t5_rst_loadn", loadn, 1);
    check_val("t5_rst_held", key_held, 0);
    check_val("t5_rst_pgt", pgt_out, 0);
    keypad = '0; run(2);
    resetn = 1'b1; run(5);
    keypad[3] = 1'b1; run(25);
    check_val("t5_code3", code, 3);
    check_val("t5_held3", key_held, 1);
    keypad = '0; run(20);

`ifdef AUTO_REPEAT_EN
    // 6: auto-repeat at 5 and then every 2 ticks after acceptance
    pulse_cnt = 0; keypad[1] = 1'b1; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin step(); if (!loadn) done = 1; end
    run(12 * DIV);
    check_val("t6_pulses", pulse_cnt, 5);
    keypad = '0; run(20);
`endif

    // Random segments
    for (int s = 0; s < 60; s++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 40);
      keypad = '0; enablen = 1'b0;
      if (sel >= 3 && sel <= 7) keypad[$urandom_range(0, NK - 1)] = 1'b1;
      else if (sel == 8) keypad = NK'($urandom);
      else if (sel == 9) begin
        keypad[$urandom_range(0, NK - 1)] = 1'b1;
        enablen = 1'($urandom_range(0, 1));
      end
      run(len);
    end
    keypad = '0; enablen = 1'b0; run(20);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
